// File: rtl/pipe_stage_chain.sv
// Generic chain of pipeline stage registers with per-stage valid, stall and flush,
// plus valid/ready handshakes toward the producer (stage 0) and consumer (last stage).
module pipe_stage_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STAGES    = 4,
  parameter int unsigned      COLLAPSE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready
);

  logic [STAGES-1:0]             v_q, v_d;
  logic [STAGES-1:0][WIDTH-1:0]  d_q, d_d;
  logic [STAGES-1:0]             hold;

  // Hold ripples from the consumer end toward stage 0; with COLLAPSE an empty
  // stage breaks the chain so bubbles get squeezed out.
  always_comb begin : hold_chain
    logic blocked;
    hold    = '0;
    blocked = ~out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      hold[STAGES-1-k] = (stall[STAGES-1-k] | blocked) &
                         ((COLLAPSE != 0) ? v_q[STAGES-1-k] : 1'b1);
      blocked = hold[STAGES-1-k];
    end
  end

  always_comb begin : next_state
    int unsigned      src;
    logic             up_hold;
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    v_d     = v_q;
    d_d     = d_q;
    src     = 0;
    up_hold = 1'b0;
    up_v    = 1'b0;
    up_d    = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      // Stage 0 treats the producer as its upstream neighbour, which never holds.
      src     = (i == 0) ? 0 : i - 1;
      up_hold = (i == 0) ? 1'b0     : hold[src];
      up_v    = (i == 0) ? in_valid : v_q[src];
      up_d    = (i == 0) ? in_data  : d_q[src];
      if (flush[i]) begin
        v_d[i] = 1'b0;
        d_d[i] = RESET_VAL;
      end else if (!hold[i]) begin
        if (up_hold) begin
          v_d[i] = 1'b0;
          d_d[i] = RESET_VAL;
        end else begin
          v_d[i] = up_v;
          d_d[i] = up_v ? up_d : RESET_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= {STAGES{RESET_VAL}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign in_ready    = ~hold[0];
  assign out_valid   = v_q[STAGES-1] & ~stall[STAGES-1];
  assign out_data    = d_q[STAGES-1];
  assign stage_valid = v_q;
  assign stage_data  = d_q;

endmodule
